// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared constants for the counter-chain lab blocks
package lab_pkg;

    // Debounce FSM state encodings, shared by every button debouncer
    localparam logic [1:0] DB_LO   = 2'd0;
    localparam logic [1:0] DB_RISE = 2'd1;
    localparam logic [1:0] DB_HI   = 2'd2;
    localparam logic [1:0] DB_FALL = 2'd3;

    // Default board clock rate
    localparam int CLK_HZ = 12_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer and debounce FSM with press pulse
module btn_debounce
    import lab_pkg::*;
#(
    parameter int DEB_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic level
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    state;
    logic [DW-1:0] dcnt;

    // Two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Level qualifier: a change is accepted after DEB_CYCLES consecutive equal samples;
    // press is registered here so it lands one cycle after the qualifying sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DB_LO;
            dcnt  <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                DB_LO: begin
                    if (sync2) begin
                        state <= DB_RISE;
                        dcnt  <= DCNT_ONE;
                    end
                end
                DB_RISE: begin
                    if (sync2) begin
                        if (dcnt == DCNT_LAST) begin
                            state <= DB_HI;
                            dcnt  <= '0;
                            press <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DCNT_ONE;
                        end
                    end else begin
                        state <= DB_LO;
                        dcnt  <= '0;
                    end
                end
                DB_HI: begin
                    if (!sync2) begin
                        state <= DB_FALL;
                        dcnt  <= DCNT_ONE;
                    end
                end
                DB_FALL: begin
                    if (!sync2) begin
                        if (dcnt == DCNT_LAST) begin
                            state <= DB_LO;
                            dcnt  <= '0;
                        end else begin
                            dcnt <= dcnt + DCNT_ONE;
                        end
                    end else begin
                        state <= DB_HI;
                        dcnt  <= '0;
                    end
                end
                default: begin
                    state <= DB_LO;
                    dcnt  <= '0;
                end
            endcase
        end
    end

    assign level = (state == DB_HI) || (state == DB_FALL);

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaled clock-enable tick with fast mode and debounced step
module tick_gen
    import lab_pkg::*;
#(
    parameter int DIV        = CLK_HZ,
    parameter int FAST_DIV   = 12_000,
    parameter int DEB_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic fast,
    input  logic step_btn,
    output logic tick,
    output logic blink,
    output logic step_seen
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] limit_last;
    logic          run_hit;
    logic          press;
    logic          step_level_unused;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .press (press),
        .level (step_level_unused)
    );

    // >= rather than == so a switch to fast with cnt already past FAST_DIV-1 wraps at once
    assign limit_last = fast ? FAST_LAST : DIV_LAST;
    assign run_hit    = run && (cnt >= limit_last);

    // Prescaler: counts while running, holds its value while stopped
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (run) begin
            if (run_hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Output register: a coincident wrap and step press merge into one tick
    always_ff @(posedge clk) begin
        if (rst) begin
            tick      <= 1'b0;
            blink     <= 1'b0;
            step_seen <= 1'b0;
        end else begin
            tick      <= run_hit | press;
            step_seen <= press;
            blink     <= blink ^ (run_hit | press);
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - scoreboard bench for tick_gen (DIV=10, FAST_DIV=3, DEB_CYCLES=4)
module tb_tick_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic fast = 1'b0;
    logic step_btn = 1'b0;
    logic tick;
    logic blink;
    logic step_seen;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int   at;
        logic step;
        logic blink;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic exp_blink = 1'b0;

    tick_gen #(
        .DIV        (10),
        .FAST_DIV   (3),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .fast      (fast),
        .step_btn  (step_btn),
        .tick      (tick),
        .blink     (blink),
        .step_seen (step_seen)
    );

    always #5 clk = ~clk;

    // Edge counter: value at a negedge is the index of the preceding posedge
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every observed tick must match the head expectation
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].at < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_tick expected at cycle %0d, still pending at cycle %0d", sb[0].at, cyc);
            sb.delete(0);
        end
        if (tick) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tick at cycle %0d step_seen=%0b blink=%0b", cyc, step_seen, blink);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.at !== cyc || mon_e.step !== step_seen || mon_e.blink !== blink) begin
                    failures++;
                    $display("FAIL tick_match got cycle=%0d step_seen=%0b blink=%0b required cycle=%0d step_seen=%0b blink=%0b",
                             cyc, step_seen, blink, mon_e.at, mon_e.step, mon_e.blink);
                end
            end
        end else if (step_seen) begin
            checks++;
            failures++;
            $display("FAIL step_seen_without_tick at cycle %0d got 1 required 0", cyc);
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input int at, input logic step);
        exp_blink = ~exp_blink;
        sb.push_back('{at, step, exp_blink});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adv(2);
        @(negedge clk);
        #1;
        checks++;
        if (tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick got %0b required 0", tick);
        end
        checks++;
        if (blink !== 1'b0) begin
            failures++;
            $display("FAIL reset_blink got %0b required 0", blink);
        end
        checks++;
        if (step_seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_step_seen got %0b required 0", step_seen);
        end
    endtask

    task automatic test_normal();
        int r;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        r = cyc;
        push_tick(r + 10, 1'b0);
        push_tick(r + 20, 1'b0);
        push_tick(r + 30, 1'b0);
        adv(35);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL normal_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_fast();
        int e;
        adv(2);
        fast = 1'b1;
        e = cyc;
        push_tick(e + 1, 1'b0);
        push_tick(e + 4, 1'b0);
        push_tick(e + 7, 1'b0);
        push_tick(e + 10, 1'b0);
        adv(10);
        fast = 1'b0;
        e = cyc;
        push_tick(e + 10, 1'b0);
        push_tick(e + 20, 1'b0);
        adv(20);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL fast_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_stop();
        int e;
        adv(4);
        run = 1'b0;
        adv(20);
        run = 1'b1;
        e = cyc;
        push_tick(e + 6, 1'b0);
        adv(6);
        run = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL stop_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_step();
        int e;
        step_btn = 1'b1;
        adv(3);
        step_btn = 1'b0;
        adv(12);
        step_btn = 1'b1;
        e = cyc;
        push_tick(e + 7, 1'b1);
        adv(50);
        step_btn = 1'b0;
        adv(12);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL step_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_coincide();
        int q;
        run = 1'b1;
        q = cyc;
        adv(3);
        step_btn = 1'b1;
        push_tick(q + 10, 1'b1);
        push_tick(q + 20, 1'b0);
        adv(9);
        step_btn = 1'b0;
        adv(8);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL coincide_drain pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int s;
        adv(4);
        step_btn = 1'b1;
        adv(4);
        rst = 1'b1;
        adv(1);
        @(negedge clk);
        #1;
        checks++;
        if (tick !== 1'b0 || blink !== 1'b0 || step_seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got tick=%0b blink=%0b step_seen=%0b required 0 0 0", tick, blink, step_seen);
        end
        rst = 1'b0;
        exp_blink = 1'b0;
        s = cyc;
        push_tick(s + 7, 1'b1);
        push_tick(s + 10, 1'b0);
        adv(12);
        step_btn = 1'b0;
        run = 1'b0;
        adv(8);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL midreset_drain pending=%0d required=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_fast();
        test_stop();
        test_step();
        test_coincide();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
